parking_slot_controller: RTL
============================

Name: parking_slot_controller

Overview:
- Sequencer that owns the parking occupancy bitmap and shares it between two requesters: an entry gate, which needs a free slot allocated, and an exit gate, which releases a slot.
- Each request is served in turn.
  - Entry: the lowest-index free slot is allocated and its one-hot location is returned.
  - Exit: the returned one-hot location is cleared.
- Sits between the gate sensors/barrier logic and the capacity-update datapath. It is the only writer of the occupancy register.

Parameters:
- NUM_SLOTS, 8, number of parking slots; width of the occupancy bitmap and of the one-hot location buses.

Ports:
- clk  input  1  single system clock; all state changes on its rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- entry_req  input  1  entry gate requests a slot; held high until entry_ack is seen.
- entry_ack  output  1  entry request served; held high until entry_req drops.
- entry_location  output  NUM_SLOTS  one-hot allocated slot; valid while entry_ack=1; zero when full.
- entry_full  output  1  valid with entry_ack; 1 means no free slot and nothing allocated.
- exit_req  input  1  exit gate releases a slot; held high until exit_ack is seen.
- exit_location  input  NUM_SLOTS  one-hot slot to release; must be stable while exit_req=1.
- exit_ack  output  1  exit request served; held high until exit_req drops.
- exit_err  output  1  valid with exit_ack; 1 means the location is not one-hot or the slot is not occupied, and nothing is cleared.
- occupancy  output  NUM_SLOTS  current bitmap (bit i = slot i occupied), registered.

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, occupancy=0, all acks/flags=0, entry_location=0, rr_last=EXIT (so entry wins the first tie). This applies from any state, including mid-handshake; the ack simply drops.
- Handshake is 4-phase:
  - Requester raises req.
  - Controller raises ack with its result.
  - Requester drops req.
  - Controller drops ack on the edge after it samples req=0, then returns to IDLE.
- FSM states: IDLE, UPDATE, ACK_ENTRY, ACK_EXIT.
  - IDLE: sample entry_req and exit_req.
    - Only one high: that requester wins.
    - Both high: the requester not equal to rr_last wins.
    - Register the winner (and a copy of exit_location if exit wins), then go to UPDATE.
    - Neither high: stay in IDLE.
  - UPDATE, entry winner:
    - occupancy != all-ones: set the lowest-index zero bit, load entry_location with its one-hot value, entry_full=0.
    - Otherwise: entry_full=1, entry_location=0, occupancy unchanged.
    - Set rr_last=ENTRY and go to ACK_ENTRY.
  - UPDATE, exit winner:
    - Latched location is one-hot and (latched & occupancy)!=0: clear that bit, exit_err=0.
    - Otherwise: exit_err=1, occupancy unchanged.
    - Set rr_last=EXIT and go to ACK_EXIT.
  - ACK_x: x_ack=1 and result outputs held stable. When x_req=0, go to IDLE with x_ack=0 and result outputs cleared to 0.
- Latency: req sampled at edge k, then occupancy and ack both updated at edge k+1. The ack is visible for at least one cycle.
- Service is one request at a time. A request arriving during another's service waits; the alternating rr_last rule prevents starvation.
- Entry and exit are never served in the same cycle, so no set/clear collision exists.
- All outputs are registered; there are no combinational paths from input to output.

Optional Feature:
- PARKING_STATS_EN
  - Defined: adds output occupied_count (clog2(NUM_SLOTS+1) bits), which is the popcount of occupancy, registered and updated at the same edge as occupancy. Also adds output total_entries (16 bits), which increments on each successful entry allocation, saturates at 0xFFFF, and is cleared by reset.
  - Undefined: neither port nor its logic exists; the behaviour of everything else is identical.

Decomposition:
- Shared package/header: FSM state encodings, requester encoding (ENTRY/EXIT) for rr_last, default NUM_SLOTS.
- One natural sub-module, free_slot_finder: combinational lowest-zero priority encoder taking the bitmap and producing a one-hot location plus a full flag.

Test Plan:
- Reset, then entry_req on empty lot -> after 1 edge, entry_ack=1, entry_location=8'b00000001, entry_full=0, occupancy=8'b00000001. Drop req -> ack=0 next edge.
- occupancy=8'b11110111, entry_req -> entry_location=8'b00001000, occupancy=8'hFF. Second entry_req -> entry_full=1, entry_location=0, occupancy stays 8'hFF.
- occupancy=8'b00100010, exit_req with exit_location=8'b00100000 -> exit_ack=1, exit_err=0, occupancy=8'b00000010.
- exit_location=8'b00000100 (unoccupied), then 8'b00000011 (not one-hot) -> exit_err=1 each time, occupancy unchanged.
- From reset, entry_req and exit_req raised in the same cycle and both held -> entry served first. After its handshake completes, exit is served. A repeat tie is then won by entry again (rr_last=EXIT).
- rst_n=0 while in ACK_ENTRY with req still high -> next edge: ack=0, occupancy=0, state IDLE. After reset the held req is served afresh, returning 8'b00000001.

Source files
------------

// File: rtl/parking_slot_controller_pkg.sv
// Shared encodings for the parking slot controller: FSM states, requester identity, default lot size.
package parking_slot_controller_pkg;

    localparam int DEFAULT_NUM_SLOTS = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        UPDATE    = 2'd1,
        ACK_ENTRY = 2'd2,
        ACK_EXIT  = 2'd3
    } state_t;

    typedef enum logic {
        REQ_ENTRY = 1'b0,
        REQ_EXIT  = 1'b1
    } requester_t;

endpackage

// File: rtl/parking_slot_controller_free_slot_finder.sv
// Lowest-index free slot finder: one-hot location of the lowest zero bit, plus a full flag.
module parking_slot_controller_free_slot_finder
    import parking_slot_controller_pkg::*;
#(
    parameter int NUM_SLOTS = DEFAULT_NUM_SLOTS
) (
    input  logic [NUM_SLOTS-1:0] occupancy,
    output logic [NUM_SLOTS-1:0] location,
    output logic                 full
);

    logic found;

    always_comb begin
        location = '0;
        found    = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!occupancy[i] && !found) begin
                location[i] = 1'b1;
                found       = 1'b1;
            end
        end
        full = &occupancy;
    end

endmodule

// File: rtl/parking_slot_controller.sv
// Parking occupancy owner arbitrating entry (allocate) and exit (release) 4-phase handshakes.
// Optional PARKING_STATS_EN adds occupied_count and a saturating total_entries counter.
module parking_slot_controller
    import parking_slot_controller_pkg::*;
#(
    parameter int NUM_SLOTS = DEFAULT_NUM_SLOTS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 entry_req,
    output logic                 entry_ack,
    output logic [NUM_SLOTS-1:0] entry_location,
    output logic                 entry_full,
    input  logic                 exit_req,
    input  logic [NUM_SLOTS-1:0] exit_location,
    output logic                 exit_ack,
    output logic                 exit_err,
    output logic [NUM_SLOTS-1:0] occupancy
`ifdef PARKING_STATS_EN
    ,
    output logic [$clog2(NUM_SLOTS+1)-1:0] occupied_count,
    output logic [15:0]                    total_entries
`endif
);

    localparam int CNT_W = $clog2(NUM_SLOTS+1);

    state_t                 state_q, state_d;
    requester_t             winner_q, winner_d;
    requester_t             rr_last_q, rr_last_d;
    logic [NUM_SLOTS-1:0]   exit_loc_q, exit_loc_d;
    logic [NUM_SLOTS-1:0]   occ_q, occ_d;
    logic [NUM_SLOTS-1:0]   entry_loc_q, entry_loc_d;
    logic                   entry_full_q, entry_full_d;
    logic                   entry_ack_q, entry_ack_d;
    logic                   exit_err_q, exit_err_d;
    logic                   exit_ack_q, exit_ack_d;
    logic [NUM_SLOTS-1:0]   free_loc;
    logic                   lot_full;

    parking_slot_controller_free_slot_finder #(
        .NUM_SLOTS (NUM_SLOTS)
    ) u_free_slot_finder (
        .occupancy (occ_q),
        .location  (free_loc),
        .full      (lot_full)
    );

    always_comb begin
        state_d      = state_q;
        winner_d     = winner_q;
        rr_last_d    = rr_last_q;
        exit_loc_d   = exit_loc_q;
        occ_d        = occ_q;
        entry_loc_d  = entry_loc_q;
        entry_full_d = entry_full_q;
        entry_ack_d  = entry_ack_q;
        exit_err_d   = exit_err_q;
        exit_ack_d   = exit_ack_q;
        case (state_q)
            IDLE: begin
                // On a tie the requester not served last time wins.
                if (entry_req && (!exit_req || rr_last_q == REQ_EXIT)) begin
                    winner_d = REQ_ENTRY;
                    state_d  = UPDATE;
                end else if (exit_req) begin
                    winner_d   = REQ_EXIT;
                    exit_loc_d = exit_location;
                    state_d    = UPDATE;
                end
            end
            UPDATE: begin
                if (winner_q == REQ_ENTRY) begin
                    if (!lot_full) begin
                        occ_d        = occ_q | free_loc;
                        entry_loc_d  = free_loc;
                        entry_full_d = 1'b0;
                    end else begin
                        entry_loc_d  = '0;
                        entry_full_d = 1'b1;
                    end
                    rr_last_d   = REQ_ENTRY;
                    entry_ack_d = 1'b1;
                    state_d     = ACK_ENTRY;
                end else begin
                    if ($onehot(exit_loc_q) && ((exit_loc_q & occ_q) != '0)) begin
                        occ_d      = occ_q & ~exit_loc_q;
                        exit_err_d = 1'b0;
                    end else begin
                        exit_err_d = 1'b1;
                    end
                    rr_last_d  = REQ_EXIT;
                    exit_ack_d = 1'b1;
                    state_d    = ACK_EXIT;
                end
            end
            ACK_ENTRY: begin
                if (!entry_req) begin
                    entry_ack_d  = 1'b0;
                    entry_loc_d  = '0;
                    entry_full_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            ACK_EXIT: begin
                if (!exit_req) begin
                    exit_ack_d = 1'b0;
                    exit_err_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            winner_q     <= REQ_ENTRY;
            rr_last_q    <= REQ_EXIT;
            occ_q        <= '0;
            entry_loc_q  <= '0;
            entry_full_q <= 1'b0;
            entry_ack_q  <= 1'b0;
            exit_err_q   <= 1'b0;
            exit_ack_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            winner_q     <= winner_d;
            rr_last_q    <= rr_last_d;
            occ_q        <= occ_d;
            entry_loc_q  <= entry_loc_d;
            entry_full_q <= entry_full_d;
            entry_ack_q  <= entry_ack_d;
            exit_err_q   <= exit_err_d;
            exit_ack_q   <= exit_ack_d;
        end
    end

    // Latched release location is only consulted in UPDATE, so it needs no reset.
    always_ff @(posedge clk) begin
        exit_loc_q <= exit_loc_d;
    end

    assign entry_ack      = entry_ack_q;
    assign entry_location = entry_loc_q;
    assign entry_full     = entry_full_q;
    assign exit_ack       = exit_ack_q;
    assign exit_err       = exit_err_q;
    assign occupancy      = occ_q;

`ifdef PARKING_STATS_EN
    logic [CNT_W-1:0] count_q, count_d;
    logic [15:0]      total_q, total_d;

    always_comb begin
        count_d = CNT_W'($countones(occ_d));
        total_d = total_q;
        if (state_q == UPDATE && winner_q == REQ_ENTRY && !lot_full && total_q != 16'hFFFF) begin
            total_d = total_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
            total_q <= '0;
        end else begin
            count_q <= count_d;
            total_q <= total_d;
        end
    end

    assign occupied_count = count_q;
    assign total_entries  = total_q;
`endif

endmodule
